// File: rtl/core_wb_pkg.sv
// Shared types and constants for the writeback stage.
// Holds the FSM state encoding and the datapath and register-file sizes.
package core_wb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REGS       = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWaitLoad,
        StCommit,
        StHold
    } wb_state_e;

endpackage

// File: rtl/core_wb_scoreboard.sv
// Per-register busy vector used by decode to stall on pending writes.
// Set has priority over clear on the same bit; bit 0 (x0) never goes busy.
module core_wb_scoreboard
    import core_wb_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic [REGS-1:0]       busy
);

    logic [REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/core_wb.sv
// Writeback stage: sole writer of the register file and PC write ports.
// Drives the delayed-write protocol (WE in COMMIT, address/data held through HOLD).
module core_wb
    import core_wb_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EX_VALID,
    output logic                  EX_READY,
    input  logic [REG_ADDR_W-1:0] EX_RD,
    input  logic [XLEN-1:0]       EX_DATA,
    input  logic                  EX_LOAD,
    input  logic                  EX_PC_WE,
    input  logic [XLEN-1:0]       EX_PC_WDATA,
    input  logic                  MEM_VALID,
    input  logic [XLEN-1:0]       MEM_RDATA,
    output logic                  WE,
    output logic [REG_ADDR_W-1:0] WADDR,
    output logic [XLEN-1:0]       WDATA,
    output logic                  PC_WE,
    output logic [XLEN-1:0]       PC_WDATA,
    output logic [REGS-1:0]       BUSY,
    output logic                  FWD_VALID,
    output logic [REG_ADDR_W-1:0] FWD_ADDR,
    output logic [XLEN-1:0]       FWD_DATA
);

    wb_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic                  pc_we_q;
    logic [XLEN-1:0]       pc_wdata_q;
    logic                  accept;

    assign EX_READY = (state_q == StIdle) || (state_q == StHold);
    assign accept   = EX_VALID & EX_READY;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        data_d  = data_q;
        case (state_q)
            // HOLD keeps rd_q/data_q on the write port; a new latch lands after the write edge.
            StIdle, StHold: begin
                state_d = StIdle;
                if (accept) begin
                    rd_d   = EX_RD;
                    data_d = EX_DATA;
                    if (EX_LOAD) begin
                        state_d = StWaitLoad;
                    end else if (EX_RD != '0) begin
                        state_d = StCommit;
                    end
                end
            end
            StWaitLoad: begin
                if (MEM_VALID) begin
                    data_d  = MEM_RDATA;
                    state_d = (rd_q != '0) ? StCommit : StIdle;
                end
            end
            StCommit: begin
                state_d = StHold;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            rd_q       <= '0;
            data_q     <= '0;
            pc_we_q    <= 1'b0;
            pc_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            pc_we_q <= accept & EX_PC_WE;
            if (accept & EX_PC_WE) begin
                pc_wdata_q <= EX_PC_WDATA;
            end
        end
    end

    core_wb_scoreboard u_scoreboard (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .set_en   (accept && (EX_RD != '0)),
        .set_addr (EX_RD),
        .clr_en   (state_q == StHold),
        .clr_addr (rd_q),
        .busy     (BUSY)
    );

    assign WE        = (state_q == StCommit);
    assign WADDR     = rd_q;
    assign WDATA     = data_q;
    assign PC_WE     = pc_we_q;
    assign PC_WDATA  = pc_wdata_q;
    assign FWD_VALID = (state_q == StCommit) || (state_q == StHold);
    assign FWD_ADDR  = FWD_VALID ? rd_q : '0;
    assign FWD_DATA  = FWD_VALID ? data_q : '0;

endmodule

// File: doc/core_wb.md
# core_wb

Writeback stage of the core: sole writer of the register file write port and PC write port.
- Accepts one result per handshake from execute (ALU value or pending load), waits for load data from memory, then drives WE/WADDR/WDATA under the register file's delayed-write protocol.
- Maintains a per-register busy scoreboard for decode stalls and a forwarding tap covering the write-to-readable window.

## Interface
- XLEN, 32, datapath width
- REGS, 32, architectural registers (x0 hardwired zero)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- EX_VALID  in  1  execute result valid
- EX_READY  out  1  core_wb can accept a result
- EX_RD  in  5  destination register
- EX_DATA  in  XLEN  result value; ignored when EX_LOAD=1
- EX_LOAD  in  1  value arrives later on MEM_RDATA
- EX_PC_WE  in  1  result carries a PC update
- EX_PC_WDATA  in  XLEN  new PC
- MEM_VALID  in  1  load data valid, single-cycle pulse
- MEM_RDATA  in  XLEN  load data
- WE  out  1  register file write enable (one-cycle pulse)
- WADDR  out  5  register file write address
- WDATA  out  XLEN  register file write data
- PC_WE  out  1  PC write enable pulse
- PC_WDATA  out  XLEN  PC write data
- BUSY  out  REGS  scoreboard; BUSY[0] always 0
- FWD_VALID  out  1  forwarding tap valid
- FWD_ADDR  out  5  forwarded register
- FWD_DATA  out  XLEN  forwarded value

## Operation
- Register file write protocol: register file samples WE one cycle late. core_wb pulses WE in COMMIT and holds WADDR/WDATA unchanged through the following HOLD cycle; the write lands at the edge ending HOLD.
- FSM states: IDLE, WAIT_LOAD, COMMIT, HOLD.
- EX_READY = 1 in IDLE and HOLD, 0 otherwise.
- On accept (EX_VALID & EX_READY), latch rd/data:
  - EX_LOAD=1 -> WAIT_LOAD.
  - Else rd!=0 -> COMMIT.
  - Else -> IDLE; result discarded, no WE.
- WAIT_LOAD: on MEM_VALID, latch MEM_RDATA. rd!=0 -> COMMIT, else -> IDLE. MEM_VALID in any other state is ignored.
- COMMIT: WE=1 -> HOLD.
- HOLD: WE=0, WADDR/WDATA held. Next state from the accept rules above if a new result is accepted this cycle, else IDLE. The new latch takes effect after the write edge.
- PC path is independent of FSM: on accept with EX_PC_WE=1, PC_WE=1 for the next cycle and PC_WDATA=EX_PC_WDATA. PC_WDATA holds until the next PC update.
- Scoreboard:
  - BUSY[rd] set at the accept edge when rd!=0.
  - BUSY[rd] cleared at the edge ending HOLD.
  - Same-bit set and clear on one edge: set wins.
- Forwarding: FWD_VALID=1 in COMMIT and HOLD with FWD_ADDR/FWD_DATA = latched rd/data. This covers reads issued before the value is readable from the register file.
- Reset (any time, incl. mid-write or during WAIT_LOAD):
  - Immediately: state IDLE, pending write dropped.
  - All outputs 0: WE, WADDR, WDATA, PC_WE, PC_WDATA, BUSY, FWD_*.
  - EX_READY=1 once out of reset.

## Timing
- ALU result accepted in cycle 0:
  - COMMIT (WE=1) in cycle 1; HOLD in cycle 2; write lands at end of cycle 2.
  - BUSY bit high in cycles 1–2, low in cycle 3.
- Load accepted in cycle 0, MEM_VALID in cycle k>=1: COMMIT in k+1, HOLD in k+2.
- Sustained ALU throughput: one write per 2 cycles (accept in HOLD).
- PC_WE latency 1 cycle after accept; never more than one cycle high per accept.
- No combinational path from inputs to outputs except EX_READY (state only).

## Structure
- Package core_wb_pkg: state enum (IDLE, WAIT_LOAD, COMMIT, HOLD), XLEN, REG_ADDR_W=5, REGS.
- Sub-module core_wb_scoreboard: REGS-bit busy vector with set/clear ports and set-priority. Bit 0 is tied to 0.
- Top: FSM, rd/data latch, PC pulse register, forwarding outputs.

## Test plan
- Reset then ALU result rd=5, data=0xDEADBEEF at cycle 0 -> WE=1 cycle 1, WADDR=5/WDATA=0xDEADBEEF cycles 1–2, BUSY[5]=1 cycles 1–2, FWD_VALID cycles 1–2.
- Load rd=7, MEM_VALID+MEM_RDATA=0x1234 after 4 cycles -> EX_READY=0 throughout wait, WE at k+1 with WDATA=0x1234. Spurious MEM_VALID in IDLE causes no write.
- Back-to-back ALU results rd=3 then rd=3 (second accepted in HOLD) -> two WE pulses 2 cycles apart; BUSY[3] stays 1 across both (set wins).
- rd=0 with EX_PC_WE=1, PC=0x80 -> no WE, BUSY unchanged, PC_WE=1 one cycle with PC_WDATA=0x80.
- RST_N low mid-COMMIT and mid-WAIT_LOAD -> WE, BUSY, FWD_VALID drop to 0 asynchronously; first result after release behaves as the ALU case.
- Bench register-file model with one-cycle-delayed WE: random result stream vs. reference array -> contents match; BUSY never 1 for x0.
